muldiv_unit: RTL and testbench



---
 rtl/muldiv_unit.sv | 191 +++++++++++++++++++
 tb/tb_muldiv_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
//
// Iterative multiply/divide unit for the MIPS datapath. Executes MULTU, MULT,
// DIVU and DIV over WIDTH+2 busy cycles and holds the results in the
// architectural HI/LO registers, which also accept MTHI/MTLO writes while idle.
//
// Ports:
//   clk            clock, all state updates on the rising edge
//   reset          synchronous active-high reset
//   start          request a new operation (sampled only while idle)
//   op[1:0]        00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   a, b           multiplicand/dividend (rs), multiplier/divisor (rt)
//   we_hi, we_lo   MTHI/MTLO write enables (ignored while busy or on start)
//   wdata          MTHI/MTLO write data
//   busy           operation in flight
//   done           one-cycle pulse: new HI/LO/dz visible
//   dz             divide-by-zero flag of the last operation
//   hi, lo         HI/LO registers
// -----------------------------------------------------------------------------
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             we_hi,
  input  logic             we_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             dz,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_PREP = 2'd1;
  localparam logic [1:0] S_CALC = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [CW-1:0] LAST_ITER = CW'(WIDTH - 1);

  logic [1:0]         r_state;
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_a;       // original operands, kept for the whole op
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_opnd;    // multiplicand or divisor magnitude
  logic [2*WIDTH-1:0] r_acc;     // product, or {remainder, dividend/quotient}
  logic [CW-1:0]      r_cnt;
  logic               r_neg_res; // negate product / quotient
  logic               r_neg_rem; // negate remainder (dividend sign)
  logic               r_busy;
  logic               r_done;
  logic               r_dz;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_is_div;
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic [WIDTH:0]     w_mul_sum;
  logic [WIDTH:0]     w_div_shift;
  logic [WIDTH:0]     w_div_sub;
  logic               w_div_fits;
  logic [WIDTH-1:0]   w_div_rem;
  logic [2*WIDTH-1:0] w_calc_next;
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rem;
  logic               w_b_zero;

  assign w_is_div = r_op[1];
  assign w_signed = r_op[0];

  // Magnitudes; the most negative value maps onto 2^(WIDTH-1) unsigned.
  assign w_a_neg = w_signed & r_a[WIDTH-1];
  assign w_b_neg = w_signed & r_b[WIDTH-1];
  assign w_a_mag = w_a_neg ? (~r_a + 1'b1) : r_a;
  assign w_b_mag = w_b_neg ? (~r_b + 1'b1) : r_b;

  // Shift-add multiply step: add multiplicand into the upper half when the
  // current multiplier bit (acc LSB) is set, then shift the whole thing right.
  assign w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} +
                     (r_acc[0] ? {1'b0, r_opnd} : {(WIDTH+1){1'b0}});

  // Restoring divide step. The partial remainder is always below the divisor,
  // so the shifted value is below twice the divisor and bit WIDTH of the
  // difference is a clean borrow indicator (for a non-zero divisor).
  assign w_div_shift = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_sub   = w_div_shift - {1'b0, r_opnd};
  assign w_div_fits  = ~w_div_sub[WIDTH];
  assign w_div_rem   = w_div_fits ? w_div_sub[WIDTH-1:0] : w_div_shift[WIDTH-1:0];

  assign w_calc_next = w_is_div ? {w_div_rem, r_acc[WIDTH-2:0], w_div_fits}
                                : {w_mul_sum, r_acc[WIDTH-1:1]};

  // Sign correction for the final write-back.
  assign w_prod   = r_neg_res ? (~r_acc + 1'b1) : r_acc;
  assign w_quo    = r_neg_res ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
  assign w_rem    = r_neg_rem ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
  assign w_b_zero = (r_b == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= S_IDLE;
      r_op      <= 2'b00;
      r_a       <= '0;
      r_b       <= '0;
      r_opnd    <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg_res <= 1'b0;
      r_neg_rem <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_dz      <= 1'b0;
      r_hi      <= '0;
      r_lo      <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            // A start in the same cycle as MTHI/MTLO drops the write.
            r_a     <= a;
            r_b     <= b;
            r_op    <= op;
            r_busy  <= 1'b1;
            r_state <= S_PREP;
          end else begin
            if (we_hi) r_hi <= wdata;
            if (we_lo) r_lo <= wdata;
          end
        end
        S_PREP: begin
          r_neg_res <= w_a_neg ^ w_b_neg;
          r_neg_rem <= w_a_neg;
          r_cnt     <= '0;
          if (w_is_div) begin
            r_acc  <= {{WIDTH{1'b0}}, w_a_mag};
            r_opnd <= w_b_mag;
          end else begin
            r_acc  <= {{WIDTH{1'b0}}, w_b_mag};
            r_opnd <= w_a_mag;
          end
          r_state <= S_CALC;
        end
        S_CALC: begin
          r_acc <= w_calc_next;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == LAST_ITER) r_state <= S_FIX;
        end
        S_FIX: begin
          if (!w_is_div) begin
            r_hi <= w_prod[2*WIDTH-1:WIDTH];
            r_lo <= w_prod[WIDTH-1:0];
            r_dz <= 1'b0;
          end else if (w_b_zero) begin
            r_hi <= r_a;
            r_lo <= '1;
            r_dz <= 1'b1;
          end else begin
            r_hi <= w_rem;
            r_lo <= w_quo;
            r_dz <= 1'b0;
          end
          r_busy  <= 1'b0;
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = r_busy;
  assign done = r_done;
  assign dz   = r_dz;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
//
// Directed bench for muldiv_unit: a 32-bit instance driven from a vector table
// (each op launched in the done cycle of the previous one) plus hand-written
// sequences for MTHI/MTLO, ignored start/writes while busy, reset mid-op, and
// an 8-bit instance for the small-width latency/corner cases.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;

  logic        s32_start, s32_we_hi, s32_we_lo;
  logic [1:0]  s32_op;
  logic [31:0] s32_a, s32_b, s32_wdata;
  logic        s32_busy, s32_done, s32_dz;
  logic [31:0] s32_hi, s32_lo;

  logic        s8_start, s8_we_hi, s8_we_lo;
  logic [1:0]  s8_op;
  logic [7:0]  s8_a, s8_b, s8_wdata;
  logic        s8_busy, s8_done, s8_dz;
  logic [7:0]  s8_hi, s8_lo;

  muldiv_unit #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(s32_start), .op(s32_op),
    .a(s32_a), .b(s32_b), .we_hi(s32_we_hi), .we_lo(s32_we_lo),
    .wdata(s32_wdata), .busy(s32_busy), .done(s32_done), .dz(s32_dz),
    .hi(s32_hi), .lo(s32_lo)
  );

  muldiv_unit #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(s8_start), .op(s8_op),
    .a(s8_a), .b(s8_b), .we_hi(s8_we_hi), .we_lo(s8_we_lo),
    .wdata(s8_wdata), .busy(s8_busy), .done(s8_done), .dz(s8_dz),
    .hi(s8_hi), .lo(s8_lo)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // inj_we: -1 none, 0 together with start, n>0 in busy cycle T+n.
  // inj_start: 0 none, n>0 a second start in cycle T+n.
  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dz;
    int          inj_start;
    int          inj_we;
  } vec_t;

  vec_t vecs[12];

  // Launches one 32-bit op at the current negedge and returns at the negedge
  // of its done cycle (or after the cycle budget).
  task automatic run32(input int idx, input vec_t v);
    int          busy_cnt;
    int          done_at;
    logic        hold_ok;
    logic [31:0] old_hi;
    logic [31:0] old_lo;
    old_hi    = s32_hi;
    old_lo    = s32_lo;
    s32_op    = v.op;
    s32_a     = v.a;
    s32_b     = v.b;
    s32_start = 1'b1;
    s32_wdata = 32'hDEADBEEF;
    s32_we_hi = (v.inj_we == 0);
    s32_we_lo = (v.inj_we == 0);
    busy_cnt  = 0;
    done_at   = 0;
    hold_ok   = 1'b1;
    for (int n = 1; n <= 60 && done_at == 0; n++) begin
      @(negedge clk);
      s32_start = (n == v.inj_start);
      if (n == v.inj_start) begin
        s32_op = ~v.op;
        s32_a  = 32'h11111111;
        s32_b  = 32'h00000003;
      end
      s32_we_hi = (n == v.inj_we);
      s32_we_lo = (n == v.inj_we);
      if (s32_busy) busy_cnt++;
      if (s32_done) done_at = n;
      else if (s32_hi !== old_hi || s32_lo !== old_lo) hold_ok = 1'b0;
    end
    s32_start = 1'b0;
    s32_we_hi = 1'b0;
    s32_we_lo = 1'b0;
    check($sformatf("v%0d latency", idx), 32'(done_at), 32'd35);
    check($sformatf("v%0d busy_cycles", idx), 32'(busy_cnt), 32'd34);
    check($sformatf("v%0d hilo_hold", idx), {31'd0, hold_ok}, 32'd1);
    check($sformatf("v%0d hi", idx), s32_hi, v.hi);
    check($sformatf("v%0d lo", idx), s32_lo, v.lo);
    check($sformatf("v%0d dz", idx), {31'd0, s32_dz}, {31'd0, v.dz});
    $display("v%0d op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d done@T+%0d",
             idx, v.op, v.a, v.b, s32_hi, s32_lo, s32_dz, done_at);
  endtask

  task automatic run8(input string name, input logic [1:0] op, input logic [7:0] a,
                      input logic [7:0] b, input logic [7:0] ehi, input logic [7:0] elo,
                      input logic edz);
    int done_at;
    s8_op    = op;
    s8_a     = a;
    s8_b     = b;
    s8_start = 1'b1;
    done_at  = 0;
    for (int n = 1; n <= 30 && done_at == 0; n++) begin
      @(negedge clk);
      s8_start = 1'b0;
      if (s8_done) done_at = n;
    end
    check({name, " latency"}, 32'(done_at), 32'd11);
    check({name, " hi"}, {24'd0, s8_hi}, {24'd0, ehi});
    check({name, " lo"}, {24'd0, s8_lo}, {24'd0, elo});
    check({name, " dz"}, {31'd0, s8_dz}, {31'd0, edz});
    $display("%s op=%0d a=%h b=%h -> hi=%h lo=%h dz=%0d done@T+%0d",
             name, op, a, b, s8_hi, s8_lo, s8_dz, done_at);
  endtask

  initial begin
    logic saw_done;

    //             op     a             b             hi            lo            dz  ist iwe
    vecs[0]  = '{2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 0, -1};
    vecs[1]  = '{2'b01, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 0, -1};
    vecs[2]  = '{2'b11, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 0, -1};
    vecs[3]  = '{2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 0, -1};
    vecs[4]  = '{2'b10, 32'h00000005, 32'h00000000, 32'h00000005, 32'hFFFFFFFF, 1'b1, 0, -1};
    vecs[5]  = '{2'b00, 32'h00000003, 32'h00000004, 32'h00000000, 32'h0000000C, 1'b0, 0,  0};
    vecs[6]  = '{2'b11, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 10, -1};
    vecs[7]  = '{2'b10, 32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E, 1'b0, 0,  5};
    vecs[8]  = '{2'b11, 32'hFFFFFFF8, 32'h00000000, 32'hFFFFFFF8, 32'hFFFFFFFF, 1'b1, 0, -1};
    vecs[9]  = '{2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 0, -1};
    vecs[10] = '{2'b10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF, 1'b0, 0, -1};
    vecs[11] = '{2'b01, 32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 0, -1};

    reset = 1'b1;
    s32_start = 1'b0; s32_we_hi = 1'b0; s32_we_lo = 1'b0; s32_op = 2'b00;
    s32_a = '0; s32_b = '0; s32_wdata = '0;
    s8_start = 1'b0; s8_we_hi = 1'b0; s8_we_lo = 1'b0; s8_op = 2'b00;
    s8_a = '0; s8_b = '0; s8_wdata = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    check("reset busy", {31'd0, s32_busy}, 32'd0);
    check("reset done", {31'd0, s32_done}, 32'd0);
    check("reset dz",   {31'd0, s32_dz},   32'd0);
    check("reset hi",   s32_hi, 32'd0);
    check("reset lo",   s32_lo, 32'd0);
    $display("reset: busy=%0d done=%0d dz=%0d hi=%h lo=%h", s32_busy, s32_done, s32_dz, s32_hi, s32_lo);

    // MTHI / MTLO while idle, separately and in the same cycle.
    s32_we_hi = 1'b1; s32_wdata = 32'h12345678;
    @(negedge clk);
    check("mthi hi", s32_hi, 32'h12345678);
    s32_we_hi = 1'b0; s32_we_lo = 1'b1; s32_wdata = 32'h9ABCDEF0;
    @(negedge clk);
    check("mtlo lo", s32_lo, 32'h9ABCDEF0);
    check("mtlo hi_kept", s32_hi, 32'h12345678);
    s32_we_hi = 1'b1; s32_we_lo = 1'b1; s32_wdata = 32'h0F0F0F0F;
    @(negedge clk);
    s32_we_hi = 1'b0; s32_we_lo = 1'b0;
    check("mthilo hi", s32_hi, 32'h0F0F0F0F);
    check("mthilo lo", s32_lo, 32'h0F0F0F0F);
    $display("mthi/mtlo: hi=%h lo=%h", s32_hi, s32_lo);

    // Table: each op starts in the done cycle of the previous one.
    for (int i = 0; i < 12; i++) run32(i, vecs[i]);

    // done must be a single-cycle pulse.
    @(negedge clk);
    check("done pulse_width", {31'd0, s32_done}, 32'd0);
    $display("done after pulse: %0d", s32_done);

    // Reset in the middle of a DIVU.
    s32_op = 2'b10; s32_a = 32'd100; s32_b = 32'd7; s32_start = 1'b1;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      s32_start = 1'b0;
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midreset busy", {31'd0, s32_busy}, 32'd0);
    check("midreset hi",   s32_hi, 32'd0);
    check("midreset lo",   s32_lo, 32'd0);
    saw_done = s32_done;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (s32_done || s32_busy) saw_done = 1'b1;
    end
    check("midreset no_done", {31'd0, saw_done}, 32'd0);
    $display("midreset: busy=%0d hi=%h lo=%h activity=%0d", s32_busy, s32_hi, s32_lo, saw_done);

    // Small-width instance.
    run8("w8 mult", 2'b01, 8'h80, 8'h80, 8'h40, 8'h00, 1'b0);
    run8("w8 div_ovf", 2'b11, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b0);
    run8("w8 divu_dz", 2'b10, 8'h64, 8'h00, 8'h64, 8'hFF, 1'b1);
    run8("w8 multu", 2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
